fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised hazard-detection and forwarding unit for the in-order integer pipeline. It sits beside the ID stage, between the IF/ID register and the ID/EX register. It tracks every in-flight destination register in a shift-register scoreboard of `DEPTH` post-ID stages. For each of `NRS` source operands it selects register-file or stage-result data, raises a load-use or interlock stall, and squashes scoreboard entries on a branch flush. It replaces the fixed 3-stage, 2-source, forward-only detection logic and adds configurable load latency, an interlock-only mode and saturating stall/forward counters.

## Interface
- `XLEN`, 32: data width.
- `NREG`, 32: architectural registers; register 0 never matches.
- `DEPTH`, 3: tracked post-ID stages. Index 0 is EX; index `DEPTH-1` is WB.
- `NRS`, 2: source read ports.
- `LOAD_STAGE`, 1: first stage index at which load data is valid on `stage_result`.
- `FLUSH_STAGES`, 1: number of youngest scoreboard entries killed by `flush`.
- `FWD_EN`, 1: 1 = forwarding; 0 = interlock-only.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset. One clock domain; reset is asynchronous and active-low.
- `issue_valid`, in, 1: ID holds a valid instruction.
- `issue_rd`, in, $clog2(NREG): destination of the ID instruction.
- `issue_wr`, in, 1: the ID instruction writes `issue_rd`.
- `issue_load`, in, 1: the ID instruction is a load.
- `rs_idx[NRS]`, in, $clog2(NREG) each: source indices of the ID instruction.
- `rs_used[NRS]`, in, 1 each: the source is actually read.
- `stage_result[DEPTH]`, in, XLEN each: current result of each stage (ALU, MEM, WB).
- `flush`, in, 1: taken branch resolved this cycle.
- `stall`, out, 1: hold the PC and IF/ID; insert a bubble into ID/EX.
- `fwd_sel[NRS]`, out, $clog2(DEPTH+1) each: 0 selects the register file; k+1 selects stage k.
- `fwd_data[NRS]`, out, XLEN each: `stage_result[fwd_sel-1]`, or 0 when `fwd_sel`=0.
- `stall_cnt`, out, 32: saturating count of cycles with `stall` asserted.
- `fwd_cnt`, out, 32: saturating count of operands forwarded on non-stalled issues.

## Operation
- Each scoreboard entry holds {v, rd, wr, load}.
- An entry "matches" port p when all of the following hold: `rs_used[p]`, v, wr, `rd==rs_idx[p]`, `rs_idx[p]!=0`.
- The youngest matching entry (lowest index) is the only one considered for port p.
- Ready rule: an entry at index k is ready when `!load || k>=LOAD_STAGE`.
- `FWD_EN=1`:
  - Youngest match ready: `fwd_sel=k+1`.
  - Youngest match not ready: assert `stall`, and `fwd_sel=0`.
- `FWD_EN=0`: any match at any index asserts `stall`, and `fwd_sel` is always 0.
- `stall` is the OR over all ports, gated by `issue_valid`.
- Shift on every clock (downstream stages never stall): `e[k+1]<=e[k]`. The entry at `DEPTH-1` retires.
- `e[0]` receives the ID instruction when `issue_valid && !stall && !flush`; otherwise it receives a bubble (v=0).
- Flush: entries at indices `< FLUSH_STAGES` shift in as bubbles. `flush` overrides `stall`, and the ID instruction is dropped.
- Counters:
  - `stall_cnt` increments when `stall` is asserted.
  - `fwd_cnt` adds the number of ports with `fwd_sel!=0` when `issue_valid && !stall && !flush`.
  - Both counters saturate at 0xFFFF_FFFF.

## Timing
- `stall`, `fwd_sel` and `fwd_data` are combinational from scoreboard state and current inputs, valid in the same cycle.
- Scoreboard and counters update on `posedge clk`.
- Asynchronous reset (`rst_n`=0): all entries have v=0 and both counters are 0. As a result `stall`=0, `fwd_sel`=0 and `fwd_data`=0 during reset.
- Reset mid-operation discards all in-flight entries immediately.
- A load-use hazard with `LOAD_STAGE=1` costs exactly one stall cycle. The next cycle the load sits at index 1 and forwards from it.
- Interlock mode stalls until the producer retires from index `DEPTH-1`. The instruction issues the cycle after retirement and reads the register file (write-before-read is assumed of the register file).
- Multiple matches: the youngest wins, e.g. a match at index 0 beats a match at index 2.

## Structure
- The shared package `pipe_pkg` holds:
  - the scoreboard entry typedef (`sb_entry_t`);
  - the `fwd_sel` encoding constants (`FWD_RF`=0);
  - the `REG_IDX_W` localparam.
- Sub-module `fwd_port_lookup`: one instance per source port. It performs the youngest-match priority search and ready check, producing the port's match, ready and select.
- The top level owns the shift register, stall OR, flush handling and counters.

## Test plan
- **ALU back-to-back:** issue `addi x5`, then `add x6,x5,x5`. Second issue: `fwd_sel[0]=fwd_sel[1]=1`, `fwd_data`=`stage_result[0]`, `stall`=0, `fwd_cnt`=2.
- **Load-use:** issue `lw x7`, then `add x8,x7,x0`. `stall`=1 for exactly one cycle; next cycle `fwd_sel[0]=2`; `stall_cnt`=1.
- **Flush:** `addi x9` in e[0] plus `flush` asserted. Next cycle, a consumer of x9 sees `fwd_sel=0` and `stall`=0.
- **Interlock (`FWD_EN=0`, `DEPTH=3`):** issue `addi x3`, then consumer of x3. `stall` is high for 3 cycles, then the consumer issues with `fwd_sel=0`.
- **Register 0 and multiple matches:**
  - Writes to x0 never stall or forward.
  - Two in-flight writes to x4 at indices 0 and 2: `fwd_sel=1`.
- **Reset mid-flight:** drop `rst_n` with 3 valid entries. Outputs are 0 immediately; after release, a consumer reads the register file.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// rtl/fwd_scoreboard_pkg.sv - shared scoreboard entry type and forwarding-select encoding
package pipe_pkg;

    localparam int MAX_NREG  = 32;
    localparam int REG_IDX_W = $clog2(MAX_NREG);

    // fwd_sel value 0 reads the register file; k+1 selects post-ID stage k
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                 v;
        logic [REG_IDX_W-1:0] rd;
        logic                 wr;
        logic                 load;
    } sb_entry_t;

    function automatic int fwd_stage_sel(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - ID-stage issue/operand bundle between decode and the scoreboard
interface fwd_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int DEPTH = 3,
    parameter int NRS   = 2
);
    localparam int RW    = $clog2(NREG);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic             issue_valid;
    logic [RW-1:0]    issue_rd;
    logic             issue_wr;
    logic             issue_load;
    logic [RW-1:0]    rs_idx       [NRS];
    logic             rs_used      [NRS];
    logic [XLEN-1:0]  stage_result [DEPTH];
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_sel      [NRS];
    logic [XLEN-1:0]  fwd_data     [NRS];
    logic [31:0]      stall_cnt;
    logic [31:0]      fwd_cnt;

    modport master (
        output issue_valid, issue_rd, issue_wr, issue_load, rs_idx, rs_used,
               stage_result, flush,
        input  stall, fwd_sel, fwd_data, stall_cnt, fwd_cnt
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wr, issue_load, rs_idx, rs_used,
               stage_result, flush,
        output stall, fwd_sel, fwd_data, stall_cnt, fwd_cnt
    );

endinterface

// File: rtl/fwd_scoreboard_port_lookup.sv
// rtl/fwd_scoreboard_port_lookup.sv - youngest-match search and readiness for one source port
module fwd_port_lookup
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = 2
) (
    input  sb_entry_t            entries_i [DEPTH],
    input  logic [REG_IDX_W-1:0] rs_idx_i,
    input  logic                 rs_used_i,
    output logic                 match_o,
    output logic                 ready_o,
    output logic [SEL_W-1:0]     sel_o
);

    // Walk oldest to youngest so the lowest matching index is the one left standing
    always_comb begin
        match_o = 1'b0;
        ready_o = 1'b0;
        sel_o   = SEL_W'(FWD_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rs_used_i && (rs_idx_i != '0) && entries_i[k].v && entries_i[k].wr &&
                (entries_i[k].rd == rs_idx_i)) begin
                match_o = 1'b1;
                ready_o = !entries_i[k].load || (k >= LOAD_STAGE);
                sel_o   = SEL_W'(fwd_stage_sel(k));
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight destination tracker with hazard stall, operand forwarding and counters
module fwd_scoreboard
    import pipe_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int DEPTH        = 3,
    parameter int NRS          = 2,
    parameter int LOAD_STAGE   = 1,
    parameter int FLUSH_STAGES = 1,
    parameter bit FWD_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_scoreboard_if.slave   sb
);

    localparam int RW    = $clog2(NREG);
    localparam int SEL_W = $clog2(DEPTH + 1);

    sb_entry_t        e_q [DEPTH];
    sb_entry_t        e_d [DEPTH];
    logic             port_match [NRS];
    logic             port_ready [NRS];
    logic [SEL_W-1:0] port_sel   [NRS];
    logic             any_hazard;
    logic             stall;
    logic             issue_fire;
    logic [31:0]      fwd_add;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic [31:0]      fwd_cnt_q, fwd_cnt_d;
    logic [32:0]      fwd_sum;
    logic [RW-1:0]    issue_rd_w;

    for (genvar p = 0; p < NRS; p++) begin : g_port
        logic [RW-1:0] rs_idx_w;
        assign rs_idx_w = sb.rs_idx[p];

        fwd_port_lookup #(
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_lookup (
            .entries_i (e_q),
            .rs_idx_i  (REG_IDX_W'(rs_idx_w)),
            .rs_used_i (sb.rs_used[p]),
            .match_o   (port_match[p]),
            .ready_o   (port_ready[p]),
            .sel_o     (port_sel[p])
        );
    end

    // Interlock mode never forwards: any live producer of a source holds the issue
    always_comb begin
        any_hazard = 1'b0;
        fwd_add    = '0;
        for (int p = 0; p < NRS; p++) begin
            sb.fwd_sel[p]  = SEL_W'(FWD_RF);
            sb.fwd_data[p] = {XLEN{1'b0}};
            if (FWD_EN) begin
                if (port_match[p] && port_ready[p]) begin
                    sb.fwd_sel[p] = port_sel[p];
                end else if (port_match[p]) begin
                    any_hazard = 1'b1;
                end
            end else if (port_match[p]) begin
                any_hazard = 1'b1;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (sb.fwd_sel[p] == SEL_W'(fwd_stage_sel(k))) begin
                    sb.fwd_data[p] = sb.stage_result[k];
                end
            end
            if (sb.fwd_sel[p] != SEL_W'(FWD_RF)) begin
                fwd_add = fwd_add + 32'd1;
            end
        end
    end

    assign stall      = sb.issue_valid && any_hazard;
    assign issue_fire = sb.issue_valid && !stall && !sb.flush;
    assign issue_rd_w = sb.issue_rd;

    // A flush kills the youngest FLUSH_STAGES entries as they advance
    always_comb begin
        e_d[0] = '0;
        if (issue_fire) begin
            e_d[0].v    = 1'b1;
            e_d[0].rd   = REG_IDX_W'(issue_rd_w);
            e_d[0].wr   = sb.issue_wr;
            e_d[0].load = sb.issue_load;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (sb.flush && ((k - 1) < FLUSH_STAGES)) begin
                e_d[k] = '0;
            end else begin
                e_d[k] = e_q[k-1];
            end
        end
    end

    assign fwd_sum     = {1'b0, fwd_cnt_q} + {1'b0, fwd_add};
    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    assign fwd_cnt_d   = !issue_fire ? fwd_cnt_q : (fwd_sum[32] ? '1 : fwd_sum[31:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                e_q[k] <= '0;
            end
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            e_q         <= e_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign sb.stall     = stall;
    assign sb.stall_cnt = stall_cnt_q;
    assign sb.fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed scoreboard-checked bench for forwarding and interlock builds
module tb_fwd_scoreboard;

    localparam logic [31:0] SR0 = 32'hA0A0_0000;
    localparam logic [31:0] SR1 = 32'hB1B1_1111;
    localparam logic [31:0] SR2 = 32'hC2C2_2222;

    typedef struct {
        string       name;
        bit          ilk;
        bit          st;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk = 1'b1;
    logic rst_n;
    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.XLEN(32), .NREG(32), .DEPTH(3), .NRS(2)) ifw ();
    fwd_scoreboard_if #(.XLEN(32), .NREG(32), .DEPTH(3), .NRS(2)) ifi ();

    fwd_scoreboard #(
        .XLEN(32), .NREG(32), .DEPTH(3), .NRS(2),
        .LOAD_STAGE(1), .FLUSH_STAGES(1), .FWD_EN(1'b1)
    ) dut_f (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (ifw)
    );

    fwd_scoreboard #(
        .XLEN(32), .NREG(32), .DEPTH(3), .NRS(2),
        .LOAD_STAGE(1), .FLUSH_STAGES(1), .FWD_EN(1'b0)
    ) dut_i (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (ifi)
    );

    task automatic apply(input bit ilk, input bit v, input int rd, input bit wr, input bit ld,
                         input int r0, input bit u0, input int r1, input bit u1, input bit fl);
        ifw.issue_valid = 1'b0; ifw.issue_rd = '0; ifw.issue_wr = 1'b0; ifw.issue_load = 1'b0;
        ifw.rs_idx[0] = '0; ifw.rs_idx[1] = '0; ifw.rs_used[0] = 1'b0; ifw.rs_used[1] = 1'b0;
        ifw.flush = 1'b0;
        ifi.issue_valid = 1'b0; ifi.issue_rd = '0; ifi.issue_wr = 1'b0; ifi.issue_load = 1'b0;
        ifi.rs_idx[0] = '0; ifi.rs_idx[1] = '0; ifi.rs_used[0] = 1'b0; ifi.rs_used[1] = 1'b0;
        ifi.flush = 1'b0;
        if (!ilk) begin
            ifw.issue_valid = v; ifw.issue_rd = 5'(rd); ifw.issue_wr = wr; ifw.issue_load = ld;
            ifw.rs_idx[0] = 5'(r0); ifw.rs_used[0] = u0;
            ifw.rs_idx[1] = 5'(r1); ifw.rs_used[1] = u1;
            ifw.flush = fl;
        end else begin
            ifi.issue_valid = v; ifi.issue_rd = 5'(rd); ifi.issue_wr = wr; ifi.issue_load = ld;
            ifi.rs_idx[0] = 5'(r0); ifi.rs_used[0] = u0;
            ifi.rs_idx[1] = 5'(r1); ifi.rs_used[1] = u1;
            ifi.flush = fl;
        end
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string name, input bit ilk, input bit st, input int s0,
                              input int s1, input logic [31:0] d0, input logic [31:0] d1,
                              input int sc, input int fc);
        exp_t x;
        x.name = name; x.ilk = ilk; x.st = st;
        x.s0 = 2'(s0); x.s1 = 2'(s1); x.d0 = d0; x.d1 = d1;
        x.sc = 32'(sc); x.fc = 32'(fc);
        expq.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t        x;
        logic        a_st;
        logic [1:0]  a_s0, a_s1;
        logic [31:0] a_d0, a_d1, a_sc, a_fc;
        while (expq.size() > 0) begin
            x = expq.pop_front();
            if (x.ilk) begin
                a_st = ifi.stall; a_s0 = ifi.fwd_sel[0]; a_s1 = ifi.fwd_sel[1];
                a_d0 = ifi.fwd_data[0]; a_d1 = ifi.fwd_data[1];
                a_sc = ifi.stall_cnt; a_fc = ifi.fwd_cnt;
            end else begin
                a_st = ifw.stall; a_s0 = ifw.fwd_sel[0]; a_s1 = ifw.fwd_sel[1];
                a_d0 = ifw.fwd_data[0]; a_d1 = ifw.fwd_data[1];
                a_sc = ifw.stall_cnt; a_fc = ifw.fwd_cnt;
            end
            n_tests++;
            if (a_st !== x.st || a_s0 !== x.s0 || a_s1 !== x.s1 || a_d0 !== x.d0 ||
                a_d1 !== x.d1 || a_sc !== x.sc || a_fc !== x.fc) begin
                n_fail++;
                $display("FAIL %s: got stall=%0b sel=%0d/%0d data=%h/%h cnt=%0d/%0d, expected stall=%0b sel=%0d/%0d data=%h/%h cnt=%0d/%0d",
                         x.name, a_st, a_s0, a_s1, a_d0, a_d1, a_sc, a_fc,
                         x.st, x.s0, x.s1, x.d0, x.d1, x.sc, x.fc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ifw.stage_result[0] = SR0; ifw.stage_result[1] = SR1; ifw.stage_result[2] = SR2;
        ifi.stage_result[0] = SR0; ifi.stage_result[1] = SR1; ifi.stage_result[2] = SR2;
        idle();
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // ALU back-to-back
        apply(0, 1, 5, 1, 0, 0, 0, 0, 0, 0); expect_out("alu_prod", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 1, 6, 1, 0, 5, 1, 5, 1, 0); expect_out("alu_b2b", 0, 0, 1, 1, SR0, SR0, 0, 0); tick();
        idle(); expect_out("alu_cnt", 0, 0, 0, 0, 0, 0, 0, 2); tick(); tick(); tick();

        // load-use
        apply(0, 1, 7, 1, 1, 0, 0, 0, 0, 0); expect_out("ld_prod", 0, 0, 0, 0, 0, 0, 0, 2); tick();
        apply(0, 1, 8, 1, 0, 7, 1, 0, 1, 0); expect_out("ld_use_stall", 0, 1, 0, 0, 0, 0, 0, 2); tick();
        apply(0, 1, 8, 1, 0, 7, 1, 0, 1, 0); expect_out("ld_use_fwd", 0, 0, 2, 0, SR1, 0, 1, 2); tick();
        idle(); expect_out("ld_cnt", 0, 0, 0, 0, 0, 0, 1, 3); tick(); tick(); tick();

        // flush
        apply(0, 1, 9, 1, 0, 0, 0, 0, 0, 0); expect_out("fl_prod", 0, 0, 0, 0, 0, 0, 1, 3); tick();
        apply(0, 1, 10, 1, 0, 9, 1, 0, 0, 1); expect_out("fl_cycle", 0, 0, 1, 0, SR0, 0, 1, 3); tick();
        apply(0, 1, 15, 0, 0, 9, 1, 10, 1, 0); expect_out("fl_after", 0, 0, 0, 0, 0, 0, 1, 3); tick();
        idle(); expect_out("fl_cnt", 0, 0, 0, 0, 0, 0, 1, 3); tick(); tick(); tick();

        // x0 never matches; youngest of two x4 producers wins
        apply(0, 1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 1, 4, 1, 0, 0, 1, 0, 1, 0); expect_out("x0_src", 0, 0, 0, 0, 0, 0, 1, 3); tick();
        apply(0, 1, 11, 1, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 1, 4, 1, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 1, 16, 0, 0, 4, 1, 11, 1, 0); expect_out("multi_young", 0, 0, 1, 2, SR0, SR1, 1, 3); tick();
        idle(); expect_out("multi_cnt", 0, 0, 0, 0, 0, 0, 1, 5); tick(); tick(); tick();

        // reset with three live entries
        apply(0, 1, 12, 1, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 1, 13, 1, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 1, 14, 1, 0, 0, 0, 0, 0, 0); tick();
        rst_n = 1'b0;
        apply(0, 1, 17, 0, 0, 12, 1, 14, 1, 0); expect_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        rst_n = 1'b1;
        apply(0, 1, 17, 0, 0, 12, 1, 14, 1, 0); expect_out("rst_after", 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // interlock-only build
        apply(1, 1, 3, 1, 0, 0, 0, 0, 0, 0); expect_out("ilk_prod", 1, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 1, 18, 0, 0, 3, 1, 0, 0, 0); expect_out("ilk_stall_e0", 1, 1, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 1, 18, 0, 0, 3, 1, 0, 0, 0); expect_out("ilk_stall_e1", 1, 1, 0, 0, 0, 0, 1, 0); tick();
        apply(1, 1, 18, 0, 0, 3, 1, 0, 0, 0); expect_out("ilk_stall_e2", 1, 1, 0, 0, 0, 0, 2, 0); tick();
        apply(1, 1, 18, 0, 0, 3, 1, 0, 0, 0); expect_out("ilk_issue", 1, 0, 0, 0, 0, 0, 3, 0); tick();
        idle(); expect_out("ilk_cnt", 1, 0, 0, 0, 0, 0, 3, 0); tick();

        @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
